// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM encoding and default operand width for the serial result collector
package serial_pkg;
  localparam int SIZE_DEF = 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
endpackage

// File: rtl/serial_result_collector_if.sv
// serial_result_collector_if: serial bit input, result stream and status signals.
// SERIAL_COLLECTOR_PARITY_EN adds RES_PARITY alongside RES_DATA.
interface serial_result_collector_if import serial_pkg::*; #(parameter int SIZE = SIZE_DEF);
  logic START, BIT_VALID, BIT_IN, CARRY_IN;
  logic RES_VALID, RES_READY, BUSY, OVERRUN;
  logic [SIZE:0] RES_DATA;
`ifdef SERIAL_COLLECTOR_PARITY_EN
  logic RES_PARITY;
  modport master(output START, BIT_VALID, BIT_IN, CARRY_IN, RES_READY,
                 input RES_DATA, RES_VALID, BUSY, OVERRUN, RES_PARITY);
  modport slave(input START, BIT_VALID, BIT_IN, CARRY_IN, RES_READY,
                output RES_DATA, RES_VALID, BUSY, OVERRUN, RES_PARITY);
`else
  modport master(output START, BIT_VALID, BIT_IN, CARRY_IN, RES_READY,
                 input RES_DATA, RES_VALID, BUSY, OVERRUN);
  modport slave(input START, BIT_VALID, BIT_IN, CARRY_IN, RES_READY,
                output RES_DATA, RES_VALID, BUSY, OVERRUN);
`endif
endinterface

// File: rtl/result_fifo2.sv
// result_fifo2: two-entry result buffer; a push into a full buffer without a pop is dropped and flagged.
module result_fifo2 #(
  parameter int W = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         overrun_o
);
  logic [W-1:0] mem_q [2];
  logic wptr_q, rptr_q, ovr_q;
  logic [1:0] cnt_q;
  logic full, do_pop, do_push;
  assign full = cnt_q == 2'(DEPTH);
  assign empty_o = cnt_q == 2'd0;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign dout_o = empty_o ? '0 : mem_q[rptr_q];
  assign overrun_o = ovr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q <= 2'd0;
      ovr_q <= 1'b0;
    end else begin
      if (do_push) mem_q[wptr_q] <= din_i;
      wptr_q <= wptr_q ^ do_push;
      rptr_q <= rptr_q ^ do_pop;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
      ovr_q <= push_i & full & ~do_pop;
    end
  end
endmodule

// File: rtl/serial_result_collector.sv
// serial_result_collector: deserialises LSB-first sum bits plus final carry into a 2-entry result buffer.
// SERIAL_COLLECTOR_PARITY_EN stores and outputs an even-parity bit per result.
module serial_result_collector import serial_pkg::*; #(
  parameter int SIZE = SIZE_DEF,
  parameter int DEPTH = 2
) (
  input logic CLK,
  input logic RST,
  serial_result_collector_if.slave bus
);
  localparam int CW = $clog2(SIZE) + 1;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:1] shreg_q, shreg_d;
  logic shift, last, empty;
  logic [SIZE:0] word;
  assign shift = state_q == COLLECT && bus.BIT_VALID && !bus.START;
  assign last = shift && cnt_q == CW'(SIZE - 1);
  assign word = {bus.CARRY_IN, bus.BIT_IN, shreg_q};
  always_comb begin
    state_d = bus.START ? COLLECT : last ? IDLE : state_q;
    cnt_d = (bus.START || last) ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    shreg_d = bus.START ? '0 : shift ? {bus.BIT_IN, shreg_q[SIZE-1:2]} : shreg_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
    end
  end
`ifdef SERIAL_COLLECTOR_PARITY_EN
  localparam int W = SIZE + 2;
  logic [W-1:0] din, dout;
  assign din = {^word, word};
  assign bus.RES_PARITY = dout[SIZE+1];
`else
  localparam int W = SIZE + 1;
  logic [W-1:0] din, dout;
  assign din = word;
`endif
  result_fifo2 #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push_i(last),
    .pop_i(bus.RES_READY),
    .din_i(din),
    .dout_o(dout),
    .empty_o(empty),
    .overrun_o(bus.OVERRUN)
  );
  assign bus.RES_DATA = dout[SIZE:0];
  assign bus.RES_VALID = ~empty;
  assign bus.BUSY = state_q == COLLECT;
endmodule

// File: tb/tb_serial_result_collector.sv
// tb_serial_result_collector: directed frame table plus hand-written buffer, restart and reset sequences.
module tb_serial_result_collector;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  serial_result_collector_if #(.SIZE(8)) bus();
  serial_result_collector #(.SIZE(8), .DEPTH(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] data;
    logic carry;
    int gap;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic start_frame;
    bus.START = 1'b1;
    bus.BIT_VALID = 1'b1;
    bus.BIT_IN = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.BIT_VALID = 1'b0;
    bus.BIT_IN = 1'b0;
  endtask
  task automatic send_bit(input logic b, input logic c, input int gap);
    int g;
    g = gap > 0 ? int'($urandom_range(gap, 0)) : 0;
    repeat (g) tick();
    bus.BIT_VALID = 1'b1;
    bus.BIT_IN = b;
    bus.CARRY_IN = c;
    tick();
    bus.BIT_VALID = 1'b0;
    bus.BIT_IN = 1'b0;
    bus.CARRY_IN = 1'b0;
  endtask
  task automatic send_bits(input logic [7:0] d, input logic c, input int gap, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i], c && i == 7, gap);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic c);
    start_frame();
    send_bits(d, c, 0, 8);
  endtask
  initial begin
    vecs[0] = '{8'h5A, 1'b1, 0, 9'h15A};
    vecs[1] = '{8'hFF, 1'b0, 3, 9'h0FF};
    vecs[2] = '{8'h00, 1'b0, 0, 9'h000};
    vecs[3] = '{8'h00, 1'b1, 1, 9'h100};
    vecs[4] = '{8'h81, 1'b0, 0, 9'h081};
    vecs[5] = '{8'hA5, 1'b1, 2, 9'h1A5};
    vecs[6] = '{8'h01, 1'b0, 0, 9'h001};
    bus.START = 1'b0;
    bus.BIT_VALID = 1'b0;
    bus.BIT_IN = 1'b0;
    bus.CARRY_IN = 1'b0;
    bus.RES_READY = 1'b1;
    #2;
    chk("rst_valid", bus.RES_VALID, 0);
    chk("rst_data", bus.RES_DATA, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_overrun", bus.OVERRUN, 0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      start_frame();
      chk("vec_busy", bus.BUSY, 1);
      send_bits(vecs[k].data, 1'b0, vecs[k].gap, 7);
      chk("vec_pre_valid", bus.RES_VALID, 0);
      send_bit(vecs[k].data[7], vecs[k].carry, vecs[k].gap);
      chk("vec_valid", bus.RES_VALID, 1);
      chk("vec_data", bus.RES_DATA, 32'(vecs[k].exp));
`ifdef SERIAL_COLLECTOR_PARITY_EN
      chk("vec_parity", bus.RES_PARITY, 32'(^vecs[k].exp));
`endif
      chk("vec_idle", bus.BUSY, 0);
      tick();
      chk("vec_one_cycle", bus.RES_VALID, 0);
    end
    // restart after a partial word: only the second frame may surface
    start_frame();
    send_bits(8'h0F, 1'b0, 0, 4);
    start_frame();
    chk("restart_busy", bus.BUSY, 1);
    send_bits(8'h81, 1'b0, 0, 8);
    chk("restart_valid", bus.RES_VALID, 1);
    chk("restart_data", bus.RES_DATA, 32'h081);
    tick();
    chk("restart_single", bus.RES_VALID, 0);
    // bits while idle are ignored
    send_bits(8'hFF, 1'b1, 0, 8);
    chk("idle_ignore", bus.RES_VALID, 0);
    // overrun: three frames into a stalled buffer
    bus.RES_READY = 1'b0;
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b0);
    chk("full_head", bus.RES_DATA, 32'h001);
    chk("full_no_ovr", bus.OVERRUN, 0);
    send_frame(8'h03, 1'b0);
    chk("ovr_pulse", bus.OVERRUN, 1);
    chk("ovr_head_kept", bus.RES_DATA, 32'h001);
    tick();
    chk("ovr_one_cycle", bus.OVERRUN, 0);
    chk("ovr_stable", bus.RES_DATA, 32'h001);
    bus.RES_READY = 1'b1;
    tick();
    chk("ovr_pop2", bus.RES_DATA, 32'h002);
    tick();
    chk("ovr_empty", bus.RES_VALID, 0);
    // push into full buffer coincident with a pop
    bus.RES_READY = 1'b0;
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b0);
    start_frame();
    send_bits(8'h03, 1'b0, 0, 7);
    chk("coin_head", bus.RES_DATA, 32'h001);
    bus.RES_READY = 1'b1;
    send_bit(1'b0, 1'b0, 0);
    chk("coin_no_ovr", bus.OVERRUN, 0);
    chk("coin_data2", bus.RES_DATA, 32'h002);
    tick();
    chk("coin_data3", bus.RES_DATA, 32'h003);
    chk("coin_no_ovr2", bus.OVERRUN, 0);
    tick();
    chk("coin_empty", bus.RES_VALID, 0);
    // asynchronous reset mid-frame with a buffered word
    bus.RES_READY = 1'b0;
    send_frame(8'h33, 1'b0);
    start_frame();
    send_bits(8'hFF, 1'b0, 0, 5);
    chk("prerst_valid", bus.RES_VALID, 1);
    chk("prerst_busy", bus.BUSY, 1);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_valid", bus.RES_VALID, 0);
    chk("arst_data", bus.RES_DATA, 0);
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_overrun", bus.OVERRUN, 0);
    tick();
    RST = 1'b0;
    bus.RES_READY = 1'b1;
    send_bits(8'hFF, 1'b1, 0, 8);
    chk("postrst_valid", bus.RES_VALID, 0);
    chk("postrst_busy", bus.BUSY, 0);
    send_frame(8'h44, 1'b1);
    chk("postrst_new_valid", bus.RES_VALID, 1);
    chk("postrst_new_data", bus.RES_DATA, 32'h144);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
